debug_dump_tx: RTL and testbench

Downstream stage of the debugger's UART receive/program-load path. On request it serialises the pipeline's debug snapshot into bytes and pushes them into the uart_top TX FIFO. The snapshot is the PC, then every register-file word, then the first NUM_MEM data-memory words. Byte order is LSB first, matching the instruction byte order the loader accepts on RX, so the host uses one word codec for both directions.

---
 rtl/debug_dump_tx_pkg.sv | 39 +++
 rtl/debug_dump_tx_if.sv | 36 +++
 rtl/debug_dump_tx_word_byte_serializer.sv | 61 ++++++
 rtl/debug_dump_tx.sv | 135 +++++++++++++
 tb/tb_debug_dump_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_dump_tx_pkg.sv
// Shared definitions for the debugger dump path.
// Contents:
//   - default geometry of the debug snapshot (PC width, register-file and
//     data-memory address widths, number of memory words dumped)
//   - BYTES_PER_WORD, also used by the RX loader's byte counter, so both
//     directions agree on the LSB-first word codec
//   - FRAME_BYTES, the length of one default dump frame
//   - section and FSM state encodings
package debug_dump_tx_pkg;

  localparam int DEF_PC       = 32;
  localparam int DEF_REG_ADDR = 5;
  localparam int DEF_MEM_ADDR = 5;
  localparam int DEF_NUM_MEM  = 32;

  localparam int BYTES_PER_WORD = DEF_PC / 8;
  localparam int FRAME_BYTES    = BYTES_PER_WORD * (1 + (2 ** DEF_REG_ADDR) + DEF_NUM_MEM);

  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_REG = 2'd1,
    SEC_MEM = 2'd2
  } section_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Frame length for a non-default geometry.
  function automatic int frame_bytes(input int pc, input int reg_addr, input int num_mem);
    return (pc / 8) * (1 + (2 ** reg_addr) + num_mem);
  endfunction

endpackage

// File: rtl/debug_dump_tx_if.sv
// Signal bundle between the dump serialiser and its surroundings
// (pipeline debug sources, register file / data memory read ports and the
// uart_top TX FIFO write side).
// Modports:
//   master - the dump engine: samples start/sources/tx_full, drives read
//            addresses, TX byte/strobe and busy/done status
//   slave  - the environment side of the same signals
interface debug_dump_tx_if #(
  parameter int PC       = 32,
  parameter int REG_ADDR = 5,
  parameter int MEM_ADDR = 5
);

  logic                i_start;
  logic [PC-1:0]       i_pc;
  logic [PC-1:0]       i_register_data;
  logic [PC-1:0]       i_memory_data;
  logic                i_tx_full;
  logic [REG_ADDR-1:0] o_addr_reg;
  logic [MEM_ADDR-1:0] o_addr_mem;
  logic [7:0]          o_w_data;
  logic                o_wr_uart;
  logic                o_busy;
  logic                o_done;

  modport master (
    input  i_start, i_pc, i_register_data, i_memory_data, i_tx_full,
    output o_addr_reg, o_addr_mem, o_w_data, o_wr_uart, o_busy, o_done
  );

  modport slave (
    output i_start, i_pc, i_register_data, i_memory_data, i_tx_full,
    input  o_addr_reg, o_addr_mem, o_w_data, o_wr_uart, o_busy, o_done
  );

endinterface

// File: rtl/debug_dump_tx_word_byte_serializer.sv
// Splits one PC-bit word into bytes, LSB first, and writes them to the TX
// FIFO with a registered strobe.
// Ports:
//   i_clock, i_reset - clock, synchronous active-high reset
//   i_load           - capture i_word and restart at byte 0
//   i_send           - owner FSM allows bytes to be issued
//   i_word           - word to serialise
//   i_tx_full        - TX FIFO full; no byte is issued while high
//   o_byte, o_wr     - registered byte and write strobe to the FIFO
//   o_last           - the final byte of the word is being issued this cycle
module debug_dump_tx_word_byte_serializer #(
  parameter int PC = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_send,
  input  logic [PC-1:0] i_word,
  input  logic          i_tx_full,
  output logic [7:0]    o_byte,
  output logic          o_wr,
  output logic          o_last
);

  localparam int BPW  = PC / 8;
  localparam int BI_W = $clog2(BPW + 1);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BPW - 1);

  logic [PC-1:0]   shift_q;
  logic [BI_W-1:0] byte_idx_q;
  logic [7:0]      byte_q;
  logic            wr_q;
  logic            fire;

  // A strobe cycle is always followed by a gap, so the FIFO full flag has
  // a cycle to reflect the previous write before the next decision.
  assign fire   = i_send && !wr_q && !i_tx_full;
  assign o_last = fire && (byte_idx_q == LAST_BYTE);
  assign o_byte = byte_q;
  assign o_wr   = wr_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
      byte_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      wr_q <= fire;
      if (i_load) begin
        shift_q    <= i_word;
        byte_idx_q <= '0;
      end else if (fire) begin
        byte_q     <= shift_q[7:0];
        shift_q    <= shift_q >> 8;
        byte_idx_q <= byte_idx_q + BI_W'(1);
      end
    end
  end

endmodule

// File: rtl/debug_dump_tx.sv
// Debug snapshot dump: on i_start, sends the PC, every register-file word
// and the first NUM_MEM data-memory words to the uart_top TX FIFO, each
// word LSB first.
// Ports:
//   i_clock, i_reset - clock, synchronous active-high reset
//   bus (master)     - start request, debug sources, read addresses,
//                      TX FIFO byte/strobe/full, busy/done status
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for i_start
// SEL      | read address for the current word is on o_addr_*
// LATCH    | source data captured into the serialiser
// SEND     | bytes of the word go out, held off by i_tx_full
// NEXT     | advance word index / section, or finish
// DONE     | one-cycle o_done pulse
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int PC       = DEF_PC,
  parameter int REG_ADDR = DEF_REG_ADDR,
  parameter int MEM_ADDR = DEF_MEM_ADDR,
  parameter int NUM_MEM  = DEF_NUM_MEM
) (
  input  logic            i_clock,
  input  logic            i_reset,
  debug_dump_tx_if.master bus
);

  localparam int NUM_REGS = 2 ** REG_ADDR;
  localparam int IDX_MAX  = (NUM_REGS > NUM_MEM) ? NUM_REGS : NUM_MEM;
  localparam int IDX_W    = $clog2(IDX_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'((NUM_MEM > 0) ? NUM_MEM - 1 : 0);

  state_e              state_q, state_n;
  section_e            sec_q, sec_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [REG_ADDR-1:0] addr_reg_q;
  logic [MEM_ADDR-1:0] addr_mem_q;
  logic [PC-1:0]       word_sel;
  logic                ser_last;

  // Addresses are registered on entry to SEL so they are stable for the
  // whole SEL cycle; a one-cycle synchronous memory then presents data
  // during LATCH, where it is captured.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      sec_q      <= SEC_PC;
      idx_q      <= '0;
      addr_reg_q <= '0;
      addr_mem_q <= '0;
    end else begin
      state_q <= state_n;
      sec_q   <= sec_n;
      idx_q   <= idx_n;
      if (state_n == ST_SEL && sec_n == SEC_REG) addr_reg_q <= REG_ADDR'(idx_n);
      if (state_n == ST_SEL && sec_n == SEC_MEM) addr_mem_q <= MEM_ADDR'(idx_n);
    end
  end

  always_comb begin
    state_n = state_q;
    sec_n   = sec_q;
    idx_n   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_n = ST_SEL;
          sec_n   = SEC_PC;
          idx_n   = '0;
        end
      end
      ST_SEL:   state_n = ST_LATCH;
      ST_LATCH: state_n = ST_SEND;
      ST_SEND: begin
        if (ser_last) state_n = ST_NEXT;
      end
      ST_NEXT: begin
        state_n = ST_SEL;
        case (sec_q)
          SEC_PC: begin
            sec_n = SEC_REG;
            idx_n = '0;
          end
          SEC_REG: begin
            if (idx_q != LAST_REG) begin
              idx_n = idx_q + IDX_W'(1);
            end else if (NUM_MEM == 0) begin
              state_n = ST_DONE;
            end else begin
              sec_n = SEC_MEM;
              idx_n = '0;
            end
          end
          SEC_MEM: begin
            if (idx_q != LAST_MEM) idx_n = idx_q + IDX_W'(1);
            else                   state_n = ST_DONE;
          end
          default: state_n = ST_DONE;
        endcase
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    word_sel = bus.i_pc;
    case (sec_q)
      SEC_REG: word_sel = bus.i_register_data;
      SEC_MEM: word_sel = bus.i_memory_data;
      default: word_sel = bus.i_pc;
    endcase
  end

  debug_dump_tx_word_byte_serializer #(.PC(PC)) u_ser (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (state_q == ST_LATCH),
    .i_send    (state_q == ST_SEND),
    .i_word    (word_sel),
    .i_tx_full (bus.i_tx_full),
    .o_byte    (bus.o_w_data),
    .o_wr      (bus.o_wr_uart),
    .o_last    (ser_last)
  );

  assign bus.o_addr_reg = addr_reg_q;
  assign bus.o_addr_mem = addr_mem_q;
  assign bus.o_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_dump_tx.sv
module tb_debug_dump_tx;

  localparam int NREG  = 32;
  localparam int NMEM  = 32;
  localparam int FRAME = 4 * (1 + NREG + NMEM);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_dump_tx_if #(.PC(32), .REG_ADDR(5), .MEM_ADDR(5)) bus ();

  debug_dump_tx #(.PC(32), .REG_ADDR(5), .MEM_ADDR(5), .NUM_MEM(NMEM)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Register file and data memory with one-cycle synchronous reads.
  logic [31:0] reg_arr [NREG];
  logic [31:0] mem_arr [32];
  logic [31:0] pc_val;
  logic [31:0] reg_rd, mem_rd;
  always @(posedge clk) begin
    reg_rd <= reg_arr[bus.o_addr_reg];
    mem_rd <= mem_arr[bus.o_addr_mem];
  end
  assign bus.i_register_data = reg_rd;
  assign bus.i_memory_data   = mem_rd;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: collects written bytes and checks per-write/per-done rules.
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int   done_cnt = 0;
  logic mon_en = 1'b0;
  logic last_full = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_wr_uart === 1'b1) begin
        got.push_back(bus.o_w_data);
        check("busy_during_write", 64'(bus.o_busy), 64'd1);
        check("write_with_full_sampled", 64'(last_full), 64'd0);
      end
      if (bus.o_done === 1'b1) begin
        done_cnt++;
        check("done_after_last_byte", 64'(got.size()), 64'(FRAME));
        check("busy_low_at_done", 64'(bus.o_busy), 64'd0);
      end
    end
    last_full = bus.i_tx_full;
  end

  // Reference frame: PC, regs, mems, each word LSB byte first.
  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic build_exp();
    exp_q.delete();
    push_word(pc_val);
    for (int r = 0; r < NREG; r++) push_word(reg_arr[r]);
    for (int m = 0; m < NMEM; m++) push_word(mem_arr[m]);
  endtask

  task automatic randomize_sources();
    pc_val = $urandom;
    for (int r = 0; r < NREG; r++) reg_arr[r] = $urandom;
    for (int m = 0; m < 32; m++)   mem_arr[m] = $urandom;
    bus.i_pc = pc_val;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic begin_dump();
    build_exp();
    got.delete();
    done_cnt = 0;
    pulse_start();
  endtask

  task automatic wait_bytes(input int n);
    int cyc = 0;
    while (got.size() < n && cyc < 20000) begin
      tick();
      cyc++;
    end
    check("wait_bytes_timeout", 64'(got.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input bit rnd_full);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 40000) begin
      if (rnd_full) bus.i_tx_full = ($urandom_range(0, 2) == 0);
      tick();
      cyc++;
    end
    bus.i_tx_full = 1'b0;
    check("wait_done_timeout", 64'(done_cnt > 0), 64'd1);
    repeat (30) tick();
  endtask

  task automatic check_frame(input string tag);
    int mism = 0;
    check({tag, "_len"}, 64'(got.size()), 64'(FRAME));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      if (got[i] !== exp_q[i]) begin
        mism++;
        if (mism <= 4) check({tag, "_byte"}, 64'(got[i]), 64'(exp_q[i]));
      end
    end
    check({tag, "_mismatches"}, 64'(mism), 64'd0);
  endtask

  int held_size;

  initial begin
    bus.i_start   = 1'b0;
    bus.i_tx_full = 1'b0;
    bus.i_pc      = '0;
    for (int r = 0; r < NREG; r++) reg_arr[r] = '0;
    for (int m = 0; m < 32; m++)   mem_arr[m] = '0;
    pc_val = '0;

    // Reset state, with i_start asserted together with reset.
    rst = 1'b1;
    bus.i_start = 1'b1;
    repeat (3) tick();
    bus.i_start = 1'b0;
    check("rst_wr_uart", 64'(bus.o_wr_uart), 64'd0);
    check("rst_busy",    64'(bus.o_busy),    64'd0);
    check("rst_done",    64'(bus.o_done),    64'd0);
    check("rst_w_data",  64'(bus.o_w_data),  64'd0);
    check("rst_addr_reg", 64'(bus.o_addr_reg), 64'd0);
    check("rst_addr_mem", 64'(bus.o_addr_mem), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_after_rst_busy", 64'(bus.o_busy), 64'd0);
    mon_en = 1'b1;

    // 1. Basic dump with directed pattern.
    pc_val = 32'h0000_0003;
    for (int r = 0; r < NREG; r++) reg_arr[r] = 32'(r);
    for (int m = 0; m < 32; m++)   mem_arr[m] = 32'h100 + 32'(m);
    bus.i_pc = pc_val;
    begin_dump();
    check("basic_busy_after_start", 64'(bus.o_busy), 64'd1);
    wait_done(1'b0);
    check_frame("basic");
    check("basic_pc_byte0",   64'(got[0]),   64'h03);
    check("basic_pc_byte1",   64'(got[1]),   64'h00);
    check("basic_reg1_byte0", 64'(got[8]),   64'h01);
    check("basic_mem0_byte1", 64'(got[133]), 64'h01);
    check("basic_mem0_byte0", 64'(got[132]), 64'h00);

    // 2. Backpressure for 20 cycles at byte 5.
    begin_dump();
    wait_bytes(5);
    bus.i_tx_full = 1'b1;
    tick();
    held_size = got.size();
    repeat (19) tick();
    check("backpressure_no_writes", 64'(got.size()), 64'(held_size));
    bus.i_tx_full = 1'b0;
    wait_done(1'b0);
    check_frame("backpressure");

    // 3. Data stability: PC changes after it has been latched.
    randomize_sources();
    build_exp();
    got.delete();
    done_cnt = 0;
    pulse_start();
    repeat (4) tick();
    bus.i_pc = 32'hFFFF_FFFF;
    wait_done(1'b0);
    check_frame("pc_stability");
    bus.i_pc = pc_val;

    // 4. Start while busy is ignored.
    randomize_sources();
    begin_dump();
    wait_bytes(50);
    pulse_start();
    wait_done(1'b0);
    check_frame("start_while_busy");

    // 5. Reset mid-dump, then a fresh dump.
    randomize_sources();
    begin_dump();
    wait_bytes(100);
    rst = 1'b1;
    tick();
    check("midrst_wr_uart", 64'(bus.o_wr_uart), 64'd0);
    check("midrst_busy",    64'(bus.o_busy),    64'd0);
    check("midrst_done",    64'(bus.o_done),    64'd0);
    rst = 1'b0;
    held_size = got.size();
    repeat (20) tick();
    check("midrst_no_more_writes", 64'(got.size()), 64'(held_size));
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    begin_dump();
    wait_done(1'b0);
    check_frame("after_reset");

    // 6. Random backpressure with random data, two rounds.
    for (int k = 0; k < 2; k++) begin
      randomize_sources();
      begin_dump();
      wait_done(1'b1);
      check_frame("random_full");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
